// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequential multiplier: op codes, FSM states,
// iteration count and op-class helpers.
package hilo_pkg;

  localparam int unsigned MUL_ITERS = 32;
  localparam int unsigned CNT_W     = 6;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_MADD  = 3'd2,
    OP_MSUB  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACC  = 2'd2
  } state_e;

  // Ops that go through the multi-cycle multiplier
  function automatic logic is_mul_op(input logic [2:0] op);
    return op <= 3'(OP_MSUB);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return op != 3'(OP_MULTU);
  endfunction

endpackage

// File: rtl/hilo_mul_core.sv
// Radix-2 shift-add unsigned multiplier: magnitude registers, 2*WIDTH partial
// product and iteration counter. One step per cycle while step_i is high.
module hilo_mul_core
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_mag_i,
  input  logic [WIDTH-1:0]   b_mag_i,
  output logic [2*WIDTH-1:0] prod_o,
  output logic               last_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = PW'(a_mag_i);
      mplier_d = b_mag_i;
      prod_d   = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      // Add the shifted multiplicand when the current multiplier bit is set
      if (mplier_q[0]) begin
        prod_d = prod_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign prod_o = prod_q;
  assign last_o = (cnt_q == CNT_W'(MUL_ITERS - 1));

endmodule

// File: rtl/hilo_mult_seq.sv
// MIPS-style HI/LO unit: sequential mult/multu/madd/msub plus mthi/mtlo,
// with sign fix-up, accumulate step and pipeline stall generation.
module hilo_mult_seq
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             ReadHiLo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned PW = 2 * WIDTH;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;

  logic             load_c, step_c, last_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;
  logic [PW-1:0]    prod_c, prod_s_c, result_c;

  assign a_mag_c = (is_signed_op(Op) && A[WIDTH-1]) ? -A : A;
  assign b_mag_c = (is_signed_op(Op) && B[WIDTH-1]) ? -B : B;

  hilo_mul_core #(.WIDTH(WIDTH)) u_core (
    .Clk     (Clk),
    .Rst     (Rst),
    .load_i  (load_c),
    .step_i  (step_c),
    .a_mag_i (a_mag_c),
    .b_mag_i (b_mag_c),
    .prod_o  (prod_c),
    .last_o  (last_c)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Start && is_mul_op(Op)) state_d = ST_RUN;
      ST_RUN:  if (last_c) state_d = ST_ACC;
      ST_ACC:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath controls and HI/LO/Done next values per state
  always_comb begin
    load_c   = 1'b0;
    step_c   = 1'b0;
    op_d     = op_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    prod_s_c = neg_q ? -prod_c : prod_c;
    result_c = prod_s_c;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_mul_op(Op)) begin
            load_c = 1'b1;
            op_d   = Op;
            neg_d  = is_signed_op(Op) & (A[WIDTH-1] ^ B[WIDTH-1]);
          end else if (Op == 3'(OP_MTHI)) begin
            hi_d   = A;
            done_d = 1'b1;
          end else if (Op == 3'(OP_MTLO)) begin
            lo_d   = A;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN: step_c = 1'b1;
      ST_ACC: begin
        if (op_q == 3'(OP_MADD)) begin
          result_c = {hi_q, lo_q} + prod_s_c;
        end else if (op_q == 3'(OP_MSUB)) begin
          result_c = {hi_q, lo_q} - prod_s_c;
        end
        hi_d   = result_c[PW-1:WIDTH];
        lo_d   = result_c[WIDTH-1:0];
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      op_q   <= '0;
      neg_q  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      neg_q  <= neg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
    end
  end

  assign Busy  = (state_q != ST_IDLE);
  assign Done  = done_q;
  assign Stall = Busy & (ReadHiLo | Start);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_hilo_mult_seq.sv
// Randomized self-checking bench for hilo_mult_seq against a 64-bit arithmetic
// reference model of HI/LO.
module tb_hilo_mult_seq;

  logic        Clk = 1'b0;
  logic        Rst, Start, ReadHiLo;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done, Stall;
  logic [31:0] HI, LO;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m, lo_m;

  hilo_mult_seq #(.WIDTH(32)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Op       (Op),
    .A        (A),
    .B        (B),
    .ReadHiLo (ReadHiLo),
    .Busy     (Busy),
    .Done     (Done),
    .Stall    (Stall),
    .HI       (HI),
    .LO       (LO)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] acc);
    longint sa, sb;
    logic [63:0] p;
    if (op == 3'd1) begin
      p = {32'd0, a} * {32'd0, b};
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end
    if (op == 3'd2) return acc + p;
    if (op == 3'd3) return acc - p;
    return p;
  endfunction

  // Multi-cycle op: checks latency, Busy/Done, Stall and HI/LO stability mid-run
  task automatic run_mul(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
    logic [63:0] exp;
    logic        st;
    exp = model(op, a, b, {hi_m, lo_m});
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a; B = b;
    @(negedge Clk);
    check({tag, ":busy0"}, 64'(Busy), 64'd1);
    for (int j = 1; j <= 33; j++) begin
      A        = $urandom;
      B        = $urandom;
      ReadHiLo = 1'($urandom_range(0, 1));
      st       = ($urandom_range(0, 3) == 0);
      Start    = st;
      Op       = 3'($urandom_range(0, 7));
      #1;
      check({tag, ":stall"}, 64'(Stall), 64'(ReadHiLo | st));
      @(negedge Clk);
      if (j < 33) begin
        if (Busy !== 1'b1 || Done !== 1'b0) begin
          check({tag, ":busy_done_mid"}, {62'd0, Busy, Done}, 64'd2);
        end
        if (HI !== hi_m || LO !== lo_m) begin
          check({tag, ":hilo_mid"}, {HI, LO}, {hi_m, lo_m});
        end
      end
    end
    Start = 1'b0; ReadHiLo = 1'b0;
    hi_m = exp[63:32];
    lo_m = exp[31:0];
    check({tag, ":done"}, 64'(Done), 64'd1);
    check({tag, ":busy_end"}, 64'(Busy), 64'd0);
    check({tag, ":hilo"}, {HI, LO}, exp);
    @(negedge Clk);
    check({tag, ":done_off"}, 64'(Done), 64'd0);
  endtask

  task automatic run_move(input logic [2:0] op, input logic [31:0] a, input string tag);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = a;
    @(negedge Clk);
    Start = 1'b0;
    if (op == 3'd4) hi_m = a;
    else lo_m = a;
    check({tag, ":hilo"}, {HI, LO}, {hi_m, lo_m});
    check({tag, ":done"}, 64'(Done), 64'd1);
    check({tag, ":busy"}, 64'(Busy), 64'd0);
    @(negedge Clk);
    check({tag, ":done_off"}, 64'(Done), 64'd0);
  endtask

  task automatic run_reserved(input logic [2:0] op);
    @(negedge Clk);
    Start = 1'b1; Op = op; A = $urandom; B = $urandom;
    @(negedge Clk);
    Start = 1'b0;
    check("rsv:busy", 64'(Busy), 64'd0);
    check("rsv:done", 64'(Done), 64'd0);
    @(negedge Clk);
    check("rsv:done2", 64'(Done), 64'd0);
    check("rsv:hilo", {HI, LO}, {hi_m, lo_m});
  endtask

  initial begin
    logic [2:0] rop;
    Rst = 1'b0; Start = 1'b0; ReadHiLo = 1'b0; Op = 3'd0; A = '0; B = '0;
    #2 Rst = 1'b1;
    #1;
    check("rst:busy", 64'(Busy), 64'd0);
    check("rst:done", 64'(Done), 64'd0);
    check("rst:hilo", {HI, LO}, 64'd0);
    hi_m = '0; lo_m = '0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;

    run_mul(3'd0, 32'hFFFF_FFFD, 32'd7, "mult_m3x7");
    check("mult_m3x7:const", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max:const", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
    run_move(3'd4, 32'd0, "mthi0");
    run_move(3'd5, 32'hFFFF_FFFF, "mtlo");
    run_mul(3'd2, 32'd1, 32'd1, "madd11");
    check("madd11:const", {HI, LO}, 64'h0000_0001_0000_0000);
    run_mul(3'd3, 32'd1, 32'd1, "msub11");
    check("msub11:const", {HI, LO}, 64'h0000_0000_FFFF_FFFF);
    run_mul(3'd0, 32'h8000_0000, 32'h8000_0000, "mult_minsq");
    check("mult_minsq:const", {HI, LO}, 64'h4000_0000_0000_0000);
    run_reserved(3'd6);
    run_reserved(3'd7);

    // Abort a mult with reset after ten cycles of RUN
    @(negedge Clk);
    Start = 1'b1; Op = 3'd0; A = $urandom; B = $urandom;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(negedge Clk);
    Rst = 1'b1;
    #1;
    check("abort:busy", 64'(Busy), 64'd0);
    check("abort:hilo", {HI, LO}, 64'd0);
    check("abort:done", 64'(Done), 64'd0);
    @(negedge Clk);
    Rst = 1'b0;
    hi_m = '0; lo_m = '0;
    for (int k = 0; k < 30; k++) begin
      @(negedge Clk);
      if (Done !== 1'b0 || Busy !== 1'b0) check("abort:quiet", {62'd0, Busy, Done}, 64'd0);
    end
    run_mul(3'd0, 32'd12345, 32'hFFFF_FF00, "after_abort");

    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      if (rop <= 3'd3) run_mul(rop, $urandom, $urandom, "rand_mul");
      else if (rop <= 3'd5) run_move(rop, $urandom, "rand_move");
      else run_reserved(rop);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
